inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle CPU core. It turns the core's PC into a request/acknowledge transaction on a variable-latency instruction memory.
- Delivers the instruction word with a valid flag and drives PCReg's ena, so the PC advances only when an instruction has actually been delivered.
- Speculatively prefetches PC+4.
- Holds one response in a buffer when the core asserts hold.

Parameters:
- RESET_TAG, 32'h0000_0000, tag loaded into the buffer on reset; it is never matched because buf_v=0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pc  in  `InstAddrBus  current PC from PCReg
- hold  in  1  core cannot accept an instruction this cycle
- inst  out  `InstBus  instruction for pc; 0 when inst_valid=0
- inst_valid  out  1  inst corresponds to word(pc)
- pc_ena  out  1  drives PCReg ena; equals inst_valid & ~hold
- im_req  out  1  instruction-memory request, registered
- im_addr  out  `InstAddrBus  request address, word-aligned (bits [1:0]=0), registered
- im_ack  in  1  one-cycle response strobe; im_rdata is valid only while im_ack=1
- im_rdata  in  `InstBus  response data
- fetch_count  out  32  number of pc_ena pulses; wraps
- stall_count  out  32  number of cycles with inst_valid=0 and hold=0; wraps

Behaviour:
- Definition: word(x)=x[31:2]. The low two bits of pc are ignored everywhere.
- State: out_v (outstanding request), buf_v, buf_tag, buf_data.
  - FSM states: IDLE (out_v=0) and WAIT (out_v=1).
  - im_req=out_v.
  - im_addr is held stable while in WAIT.
- Hit sources, both combinational, same cycle:
  - buf_hit = buf_v & word(buf_tag)==word(pc)
  - byp_hit = out_v & im_ack & word(im_addr)==word(pc)
  - inst_valid = buf_hit | byp_hit
  - inst = buf_hit ? buf_data : (byp_hit ? im_rdata : 0)
- Buffer update, at the clock edge:
  - If out_v & im_ack and the response was not consumed by bypass (byp_hit & pc_ena & ~buf_hit): buffer <= {1, im_addr, im_rdata}, overwriting.
  - Else if pc_ena & buf_hit: buf_v <= 0.
- Issue, at the clock edge; free = ~out_v | im_ack:
  - free & pc_ena: issue {word(pc)+1, 2'b00}. This is the prefetch; it wraps 0xFFFFFFFC -> 0x00000000.
  - free & ~pc_ena & ~inst_valid & ~(response being stored has word(tag)==word(pc)): issue {word(pc), 2'b00}.
  - Otherwise nothing is issued. out_v <= 0 if im_ack, else it holds.
  - Issuing sets out_v=1 and loads im_addr.
- Latency:
  - Miss detected in cycle t -> im_req in t+1.
  - With a zero-wait memory (ack in the first req cycle), the bypass delivers in t+1.
  - Sequential code on a zero-wait memory sustains 1 instruction/cycle.
  - Each memory wait state adds 1 cycle.
- Redirect (pc != prefetched address):
  - The in-flight request is not cancelled.
  - Its response is stored but not delivered.
  - The demand request is issued at that ack's edge.
- Hold:
  - inst_valid is still reported; pc_ena=0.
  - A response arriving under hold is buffered.
  - No new request is issued for an already-available pc.
- Simultaneous buffer hit consumed and ack of another address: the buffer takes the new response.
- im_ack while out_v=0 is ignored. This covers stale acks after reset.
- Reset, synchronous, takes priority over everything, including mid-transaction:
  - out_v=0, im_req=0, im_addr=0, buf_v=0, buf_tag=RESET_TAG, buf_data=0
  - fetch_count=0, stall_count=0
  - inst=0, inst_valid=0, pc_ena=0 (given pc does not match the invalid buffer)
- Counters increment on the edge; 32-bit wrap at 0xFFFFFFFF -> 0.
- The core must gate its register-file write and ram_ena with pc_ena. This is a documented integration requirement, not implemented here.

Decomposition:
- Bus-width macros (`InstBus, `InstAddrBus, `Enable/`Disable) come from the shared defines.vh. Add `IFetchIdle=1'b0 and `IFetchWait=1'b1 there.
- One natural sub-module, fetch_buf: the single-entry tagged buffer with a combinational match output.
- Counters stay inline.

Test Plan:
1. Zero-wait memory, release rst with pc=0x00400000 -> im_req rises 1 cycle after release; im_addr sequence 0x00400000, 0x00400004, 0x00400008; after the first delivery, pc_ena=1 every cycle; fetch_count=3 after 3 instructions.
2. Memory with 3 wait states, sequential code -> pc_ena pulses every 4 cycles; stall_count increments by 3 per instruction.
3. pc redirects 0x00400008 -> 0x00400100 while the prefetch of 0x0040000C is outstanding -> inst_valid=0 until the next ack for 0x00400100; 0x0040000C data is never delivered.
4. hold=1 for 3 cycles, ack for pc arrives in the first of them -> inst_valid=1 and pc_ena=0 for 3 cycles, no new im_req; hold drops -> pc_ena=1 from the buffer, and the prefetch of pc+4 is issued at that edge.
5. rst asserted while im_req=1, then memory returns a late ack -> im_req=0 the cycle after rst; the stale ack is ignored; all counters are 0.
6. pc=0xFFFFFFFC delivered -> next im_addr=0x00000000; pc=0x00400002 -> im_addr=0x00400000 and it hits as word 0x00400000.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, fetch FSM encodings and word-address helpers for the fetch stage.
// Addresses are byte addresses; everything downstream compares 30-bit word numbers.
package inst_fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int WORD_W = ADDR_W - 2;

    localparam logic [0:0] IFETCH_IDLE = 1'b0;
    localparam logic [0:0] IFETCH_WAIT = 1'b1;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t word_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2];
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input word_t w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry tagged instruction buffer; combinational hit against the current PC word.
// Write wins over clear in the same cycle; no backpressure, always accepts.
module fetch_buf
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_word,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [INST_W-1:0] wr_data,
    input  logic              clr,
    output logic              hit,
    output logic [INST_W-1:0] data
);

    logic              buf_v;
    logic [WORD_W-1:0] buf_tag;
    logic [INST_W-1:0] buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v    <= 1'b0;
            buf_tag  <= RESET_WORD;
            buf_data <= '0;
        end else if (wr_en) begin
            buf_v    <= 1'b1;
            buf_tag  <= wr_word;
            buf_data <= wr_data;
        end else if (clr) begin
            buf_v    <= 1'b0;
        end
    end

    assign hit  = buf_v & (buf_tag == pc_word);
    assign data = buf_data;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC -> req/ack instruction memory with PC+4 prefetch and a one-entry hold buffer.
// Miss seen in t -> im_req in t+1, bypass delivery on ack; hold keeps the response buffered.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_TAG = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hold,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              pc_ena,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [INST_W-1:0] im_rdata,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
);

    logic [0:0]  state;
    word_t       req_word;
    word_t       pc_word;
    logic        out_v;
    logic        buf_hit;
    logic [INST_W-1:0] buf_data;
    logic        byp_hit;
    logic        store;
    logic        store_match;
    logic        clr;
    logic        free;
    logic        issue_pf;
    logic        issue_dm;
    logic        pc_lsb_unused;

    assign pc_word       = word_of(pc);
    assign pc_lsb_unused = ^pc[1:0];
    assign out_v         = (state == IFETCH_WAIT);
    assign im_req        = out_v;
    assign im_addr       = word_addr(req_word);

    assign byp_hit    = out_v & im_ack & (req_word == pc_word);
    assign inst_valid = buf_hit | byp_hit;
    assign inst       = buf_hit ? buf_data : (byp_hit ? im_rdata : '0);
    assign pc_ena     = inst_valid & ~hold;

    // A bypassed response is only dropped when it is what the core actually took.
    assign store       = out_v & im_ack & ~(byp_hit & pc_ena & ~buf_hit);
    assign store_match = store & (req_word == pc_word);
    assign clr         = pc_ena & buf_hit;

    assign free     = ~out_v | im_ack;
    assign issue_pf = free & pc_ena;
    assign issue_dm = free & ~pc_ena & ~inst_valid & ~store_match;

    fetch_buf #(
        .RESET_WORD (RESET_TAG[ADDR_W-1:2])
    ) u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .pc_word (pc_word),
        .wr_en   (store),
        .wr_word (req_word),
        .wr_data (im_rdata),
        .clr     (clr),
        .hit     (buf_hit),
        .data    (buf_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IFETCH_IDLE;
            req_word <= '0;
        end else if (issue_pf) begin
            state    <= IFETCH_WAIT;
            req_word <= pc_word + word_t'(1);
        end else if (issue_dm) begin
            state    <= IFETCH_WAIT;
            req_word <= pc_word;
        end else if (im_ack) begin
            state    <= IFETCH_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (pc_ena)
                fetch_count <= fetch_count + 32'd1;
            if (~inst_valid & ~hold)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule
